// File: rtl/axi_dma_ch_scheduler.sv
// Round-robin scheduler feeding per-channel DMA requests to one DMA core.
// Optional macro DMA_SCHED_ERR_HALT_EN adds err_clr/ch_halted.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ch_req_valid/ready         per-channel request handshake
//   ch_req_src/dst/len         packed per-channel command fields
//   ch_done, ch_status         completion pulse and status
//   core_start, core_*_addr,
//   core_len                   command to DMA core
//   core_done/busy/status      DMA core feedback
//   intr_mask, intr_clr        interrupt mask / clear pulses
//   intr_pend_vec, intr_pend   pending bits and masked summary
//   err_clr, ch_halted         (macro only) error halt control
module axi_dma_ch_scheduler #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_src,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_dst,
  input  logic [NUM_CH*LEN_W-1:0]  ch_req_len,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [3:0]               ch_status,
  output logic                     core_start,
  output logic [ADDR_W-1:0]        core_src_addr,
  output logic [ADDR_W-1:0]        core_dst_addr,
  output logic [LEN_W-1:0]         core_len,
  input  logic                     core_done,
  input  logic                     core_busy,
  input  logic [3:0]               core_status,
  input  logic [NUM_CH-1:0]        intr_mask,
  input  logic [NUM_CH-1:0]        intr_clr,
`ifdef DMA_SCHED_ERR_HALT_EN
  input  logic [NUM_CH-1:0]        err_clr,
  output logic [NUM_CH-1:0]        ch_halted,
`endif
  output logic [NUM_CH-1:0]        intr_pend_vec,
  output logic                     intr_pend
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RETIRE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] last_q, last_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    stat_q, stat_d;

  logic [NUM_CH-1:0]             slot_v_q, slot_v_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] slot_src_q, slot_src_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] slot_dst_q, slot_dst_d;
  logic [NUM_CH-1:0][LEN_W-1:0]  slot_len_q, slot_len_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  logic          sel_found;
  logic [CW-1:0] sel_idx;
  logic          sel_zero;
  logic          go;

  // Round-robin search starting one past the last grant
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!sel_found &&
          slot_v_q[(int'(last_q) + k) % NUM_CH]) begin
        sel_found = 1'b1;
        sel_idx   = CW'((int'(last_q) + k) % NUM_CH);
      end
    end
  end

  assign sel_zero = (slot_len_q[sel_idx] == '0);
  assign go = (state_q == IDLE) && sel_found
            && !core_busy;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (go) state_d = sel_zero ? RETIRE : ISSUE;
      ISSUE:  state_d = WAIT;
      WAIT:   if (core_done) state_d = RETIRE;
      RETIRE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / register next values
  always_comb begin
    grant_d    = grant_q;
    last_d     = last_q;
    cap_d      = cap_q;
    stat_d     = stat_q;
    slot_v_d   = slot_v_q;
    slot_src_d = slot_src_q;
    slot_dst_d = slot_dst_q;
    slot_len_d = slot_len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    pend_d     = pend_q & ~intr_clr;

    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_req_valid[i] && ch_req_ready[i]) begin
        slot_v_d[i]   = 1'b1;
        slot_src_d[i] = ch_req_src[i*ADDR_W +: ADDR_W];
        slot_dst_d[i] = ch_req_dst[i*ADDR_W +: ADDR_W];
        slot_len_d[i] = ch_req_len[i*LEN_W +: LEN_W];
      end
    end

    if (go) begin
      grant_d = sel_idx;
      if (sel_zero) begin
        cap_d = 4'h0;
      end else begin
        src_d = slot_src_q[sel_idx];
        dst_d = slot_dst_q[sel_idx];
        len_d = slot_len_q[sel_idx];
      end
    end

    if (state_q == WAIT && core_done) begin
      cap_d = core_status;
    end

    // Set beats a same-cycle intr_clr
    if (state_q == RETIRE) begin
      slot_v_d[grant_q] = 1'b0;
      pend_d[grant_q]   = 1'b1;
      last_d            = grant_q;
      stat_d            = cap_q;
    end
  end

  // Outputs
  always_comb begin
    ch_done = '0;
    if (state_q == RETIRE) ch_done[grant_q] = 1'b1;
  end

  assign core_start    = (state_q == ISSUE);
  assign core_src_addr = src_q;
  assign core_dst_addr = dst_q;
  assign core_len      = len_q;
  assign ch_status     = (state_q == RETIRE) ? cap_q
                                             : stat_q;
  assign intr_pend_vec = pend_q;
  assign intr_pend     = |(pend_q & ~intr_mask);

`ifdef DMA_SCHED_ERR_HALT_EN
  logic [NUM_CH-1:0] halt_q, halt_d;

  always_comb begin
    halt_d = halt_q & ~err_clr;
    if (state_q == RETIRE && cap_q != 4'h0)
      halt_d[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= '0;
    else        halt_q <= halt_d;
  end

  assign ch_halted    = halt_q;
  assign ch_req_ready = ~slot_v_q & ~halt_q;
`else
  assign ch_req_ready = ~slot_v_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= CW'(NUM_CH - 1);
      cap_q      <= '0;
      stat_q     <= '0;
      slot_v_q   <= '0;
      slot_src_q <= '0;
      slot_dst_q <= '0;
      slot_len_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cap_q      <= cap_d;
      stat_q     <= stat_d;
      slot_v_q   <= slot_v_d;
      slot_src_q <= slot_src_d;
      slot_dst_q <= slot_dst_d;
      slot_len_q <= slot_len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_axi_dma_ch_scheduler.sv
// Testbench for axi_dma_ch_scheduler: vector table, scoreboard queues
// for core commands and completions, hand sequences for corner cases.
module tb_axi_dma_ch_scheduler;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        ch_req_valid;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH*ADDR_W-1:0] ch_req_src;
  logic [NUM_CH*ADDR_W-1:0] ch_req_dst;
  logic [NUM_CH*LEN_W-1:0]  ch_req_len;
  logic [NUM_CH-1:0]        ch_done;
  logic [3:0]               ch_status;
  logic                     core_start;
  logic [ADDR_W-1:0]        core_src_addr;
  logic [ADDR_W-1:0]        core_dst_addr;
  logic [LEN_W-1:0]         core_len;
  logic                     core_done;
  logic                     core_busy;
  logic [3:0]               core_status;
  logic [NUM_CH-1:0]        intr_mask;
  logic [NUM_CH-1:0]        intr_clr;
  logic [NUM_CH-1:0]        intr_pend_vec;
  logic                     intr_pend;
`ifdef DMA_SCHED_ERR_HALT_EN
  logic [NUM_CH-1:0]        err_clr;
  logic [NUM_CH-1:0]        ch_halted;
`endif

  axi_dma_ch_scheduler #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_valid(ch_req_valid),
    .ch_req_ready(ch_req_ready),
    .ch_req_src(ch_req_src),
    .ch_req_dst(ch_req_dst),
    .ch_req_len(ch_req_len),
    .ch_done(ch_done), .ch_status(ch_status),
    .core_start(core_start),
    .core_src_addr(core_src_addr),
    .core_dst_addr(core_dst_addr),
    .core_len(core_len),
    .core_done(core_done), .core_busy(core_busy),
    .core_status(core_status),
    .intr_mask(intr_mask), .intr_clr(intr_clr),
`ifdef DMA_SCHED_ERR_HALT_EN
    .err_clr(err_clr), .ch_halted(ch_halted),
`endif
    .intr_pend_vec(intr_pend_vec),
    .intr_pend(intr_pend)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [3:0]  st;
    logic [3:0]  exp_pend;
  } vec_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } core_exp_t;

  typedef struct {
    int         ch;
    logic [3:0] st;
  } done_exp_t;

  core_exp_t core_q[$];
  done_exp_t done_q[$];
  core_exp_t ce;
  done_exp_t de;
  logic [NUM_CH-1:0] oh;

  // Scoreboard: core commands
  always @(negedge clk) begin
    if (rst_n && core_start) begin
      if (core_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_start_unexp: got 1 want 0");
      end else begin
        ce = core_q.pop_front();
        chk("core_src", core_src_addr, ce.src);
        chk("core_dst", core_dst_addr, ce.dst);
        chk("core_len", core_len, ce.len);
      end
    end
  end

  // Scoreboard: completions
  always @(negedge clk) begin
    if (rst_n && ch_done != '0) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ch_done_unexp: got %0h want 0",
                 ch_done);
      end else begin
        de = done_q.pop_front();
        oh = '0;
        oh[de.ch] = 1'b1;
        chk("done_ch", ch_done, oh);
        chk("done_status", ch_status, de.st);
      end
    end
  end

  // Core model: answers each start after rsp_lat cycles
  logic       rsp_en;
  int         rsp_lat;
  logic [3:0] rsp_stat;
  logic       rsp_done;
  logic       man_done;

  assign core_done   = rsp_done | man_done;
  assign core_status = rsp_done ? rsp_stat : 4'h0;

  initial begin
    rsp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start && rsp_en) begin
        repeat (rsp_lat) @(negedge clk);
        rsp_done = 1'b1;
        @(negedge clk);
        rsp_done = 1'b0;
      end
    end
  end

  task automatic drive(int ch, logic [31:0] src,
                       logic [31:0] dst, logic [31:0] len);
    ch_req_valid[ch] = 1'b1;
    ch_req_src[ch*ADDR_W +: ADDR_W] = src;
    ch_req_dst[ch*ADDR_W +: ADDR_W] = dst;
    ch_req_len[ch*LEN_W +: LEN_W]   = len;
  endtask

  task automatic push(int ch, logic [31:0] src,
                      logic [31:0] dst, logic [31:0] len,
                      logic [3:0] st, bit pdone);
    core_exp_t c;
    done_exp_t d;
    c.src = src;
    c.dst = dst;
    c.len = len;
    d.ch  = ch;
    d.st  = (len == 0) ? 4'h0 : st;
    if (len != 0) core_q.push_back(c);
    if (pdone) done_q.push_back(d);
  endtask

  task automatic send(int ch, logic [31:0] src,
                      logic [31:0] dst, logic [31:0] len,
                      logic [3:0] st, bit pdone);
    @(negedge clk);
    rsp_stat = st;
    drive(ch, src, dst, len);
    push(ch, src, dst, len, st, pdone);
    @(negedge clk);
    ch_req_valid = '0;
  endtask

  task automatic wait_drain(int max);
    int n = 0;
    while ((core_q.size() != 0 || done_q.size() != 0)
           && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < max), 1);
  endtask

  task automatic wait_done(int ch, int max);
    int n = 0;
    while (!ch_done[ch] && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", (n < max), 1);
  endtask

  vec_t vt[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit saw_start;
    int bad;

    ch_req_valid = '0;
    ch_req_src   = '0;
    ch_req_dst   = '0;
    ch_req_len   = '0;
    core_busy    = 1'b0;
    intr_mask    = '0;
    intr_clr     = '0;
    man_done     = 1'b0;
    rsp_en       = 1'b1;
    rsp_lat      = 3;
    rsp_stat     = 4'h0;
`ifdef DMA_SCHED_ERR_HALT_EN
    err_clr      = '0;
`endif

    vt[0] = '{0, 32'h1000, 32'h2000, 32'h40, 4'h0, 4'b0001};
    vt[1] = '{1, 32'h1100, 32'h2100, 32'h80, 4'h0, 4'b0011};
    vt[2] = '{2, 32'h3000, 32'h4000, 32'h0,  4'h0, 4'b0111};
    vt[3] = '{3, 32'h5000, 32'h6000, 32'h10, 4'h0, 4'b1111};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", ch_req_ready, 4'hF);
    chk("rst_start", core_start, 0);
    chk("rst_src", core_src_addr, 0);
    chk("rst_len", core_len, 0);
    chk("rst_done", ch_done, 0);
    chk("rst_status", ch_status, 0);
    chk("rst_pend_vec", intr_pend_vec, 0);
    chk("rst_pend", intr_pend, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: single requests, latency and interrupt bits
    for (int i = 0; i < 4; i++) begin
      chk("ready_pre", ch_req_ready[vt[i].ch], 1);
      rsp_stat = vt[i].st;
      drive(vt[i].ch, vt[i].src, vt[i].dst, vt[i].len);
      push(vt[i].ch, vt[i].src, vt[i].dst, vt[i].len,
           vt[i].st, 1);
      lat = 0;
      saw_start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 1) ch_req_valid = '0;
        if (core_start || ch_done != '0) begin
          lat = k;
          saw_start = core_start;
          break;
        end
      end
      chk("first_evt_lat", lat, 2);
      chk("start_vs_len", saw_start, (vt[i].len != 0));
      wait_drain(100);
      repeat (2) @(negedge clk);
      chk("pend_vec", intr_pend_vec, vt[i].exp_pend);
    end

    intr_mask = 4'b0001;
    #1;
    chk("pend_masked_some", intr_pend, 1);
    intr_mask = 4'hF;
    #1;
    chk("pend_masked_all", intr_pend, 0);
    intr_mask = '0;
    @(negedge clk);
    intr_clr = 4'hF;
    @(negedge clk);
    intr_clr = '0;
    chk("pend_cleared", intr_pend_vec, 0);

    // All four channels at once, round robin order
    rsp_lat = 10;
    @(negedge clk);
    rsp_stat = 4'h0;
    for (int c = 0; c < 4; c++) begin
      drive(c, 32'hA000 + c*32'h100,
            32'hB000 + c*32'h100, 32'h20 * (c + 1));
      push(c, 32'hA000 + c*32'h100,
           32'hB000 + c*32'h100, 32'h20 * (c + 1),
           4'h0, 1);
    end
    @(negedge clk);
    ch_req_valid = '0;
    chk("rr_all_busy", ch_req_ready, 4'h0);
    wait_done(0, 100);
    @(negedge clk);
    chk("rr_ready0_back", ch_req_ready, 4'b0001);
    wait_drain(400);

    // Re-request ch0 and ch2 together: ch0 first
    @(negedge clk);
    drive(2, 32'hC200, 32'hD200, 32'h8);
    drive(0, 32'hC000, 32'hD000, 32'h4);
    push(0, 32'hC000, 32'hD000, 32'h4, 4'h0, 1);
    push(2, 32'hC200, 32'hD200, 32'h8, 4'h0, 1);
    @(negedge clk);
    ch_req_valid = '0;
    wait_drain(200);

    // Interrupt set wins over a same-cycle clear
    rsp_lat = 3;
    repeat (2) @(negedge clk);
    intr_clr = 4'hF;
    @(negedge clk);
    intr_clr = '0;
    chk("pend_cleared2", intr_pend_vec, 0);
    send(0, 32'h100, 32'h200, 32'h4, 4'h0, 1);
    wait_drain(100);
    send(1, 32'h300, 32'h400, 32'h4, 4'h0, 1);
    wait_done(1, 50);
    intr_clr = 4'b0010;
    @(negedge clk);
    intr_clr = '0;
    wait_drain(50);
    repeat (2) @(negedge clk);
    chk("set_beats_clr", intr_pend_vec, 4'b0011);
    intr_mask = 4'b0001;
    #1;
    chk("pend_mask1", intr_pend, 1);
    intr_mask = 4'b0011;
    #1;
    chk("pend_mask3", intr_pend, 0);
    intr_mask = '0;
    @(negedge clk);
    intr_clr = 4'b0010;
    @(negedge clk);
    intr_clr = '0;
    chk("clr_bit1", intr_pend_vec, 4'b0001);

    // Reset during WAIT discards the transfer
    rsp_en = 1'b0;
    send(0, 32'h7000, 32'h8000, 32'h40, 4'h0, 0);
    for (int k = 0; k < 10 && core_q.size() != 0; k++)
      @(negedge clk);
    chk("mid_issued", core_q.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", ch_req_ready, 4'hF);
    chk("mrst_start", core_start, 0);
    chk("mrst_len", core_len, 0);
    chk("mrst_pend_vec", intr_pend_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ch_done != '0 || core_start) bad++;
    end
    chk("mrst_no_done", bad, 0);
    chk("mrst_ready2", ch_req_ready, 4'hF);
    rsp_en = 1'b1;

    // Error completion on ch1
    send(1, 32'h9000, 32'h9100, 32'h20, 4'h2, 1);
    wait_done(1, 50);
    @(negedge clk);
`ifdef DMA_SCHED_ERR_HALT_EN
    chk("halted1", ch_halted, 4'b0010);
    chk("halt_ready", ch_req_ready, 4'b1101);
    repeat (2) @(negedge clk);
    chk("halt_hold", ch_req_ready, 4'b1101);
    err_clr = 4'b0010;
    @(negedge clk);
    err_clr = '0;
    chk("unhalted", ch_halted, 0);
    chk("unhalt_ready", ch_req_ready, 4'hF);
`else
    chk("err_ready", ch_req_ready, 4'hF);
`endif
    repeat (3) @(negedge clk);
    chk("status_hold", ch_status, 4'h2);
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
